mem_arbiter: RTL
================

# mem_arbiter

Arbitrates the single shared memory port between the fetch stage (instruction read requests) and the memory stage (data read/write requests). It sits between the pipeline's fetch/memory stages and the core's memory interface. It latches the winning request and holds it stable until the memory completes. It returns the response only to a requester that still wants it, so requests killed by a pipeline flush are retired silently. The hazard unit never sees requester-visible side effects from a flushed access.

## Interface
- TIMEOUT, 1024: cycles a transaction may stay outstanding before `err_timeout` sets; range 2..65535.
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- i_valid  input  1  fetch request; the requester holds it high until `i_ready`, or changes it on flush.
- i_addr  input  64  fetch address; the access is a 4-byte read.
- i_ready  output  1  single-cycle response strobe to fetch.
- i_rdata  output  64  fetch read data; valid only when `i_ready`.
- d_valid  input  1  memory-stage request.
- d_addr  input  64  data address.
- d_write  input  1  1 = store, 0 = load.
- d_size  input  3  access size code; passed through unchanged.
- d_strobe  input  8  byte-write enables; stores only.
- d_wdata  input  64  store data.
- d_ready  output  1  single-cycle response strobe to the memory stage.
- d_rdata  output  64  load data; valid only when `d_ready`.
- c_valid  output  1  downstream request valid.
- c_addr  output  64  downstream address.
- c_write  output  1  downstream write flag.
- c_size  output  3  downstream size code.
- c_strobe  output  8  downstream byte enables.
- c_wdata  output  64  downstream write data.
- c_ready  input  1  downstream completion strobe, one cycle.
- c_rdata  input  64  downstream read data; valid with `c_ready`.
- err_timeout  output  1  sticky timeout flag.

## Operation
- FSM states:
  - IDLE: no transaction outstanding.
  - BUSY_I: fetch transaction outstanding.
  - BUSY_D: data transaction outstanding.
- Arbitration, IDLE only:
  - `d_valid` → BUSY_D; data wins whenever `d_valid` is high, including when `i_valid` is also high.
  - else `i_valid` → BUSY_I.
  - else stay in IDLE.
- Grant latches the request into the `c_*` registers:
  - Fetch grant: `c_write`=0, `c_size`=3'b010, `c_strobe`=0, `c_wdata`=0.
  - The `c_*` fields stay constant for the whole transaction.
- Busy states: `c_valid`=1. On `c_ready`, return to IDLE and clear `c_valid`.
- Completion delivery: in the `c_ready` cycle, the response goes to the granted requester only if its `*_valid`=1 and its current address equals the latched `c_addr`. Otherwise the response is dropped: no ready strobe, and the data is discarded.
  - This covers a flush that redirects fetch to a new PC or kills the memory-stage instruction.
- `i_rdata`/`d_rdata` drive combinationally from `c_rdata`. `i_ready`/`d_ready` are combinational from `c_ready`, state and the match check.
- Only one ready strobe per `c_ready`. `i_ready` and `d_ready` are never both 1.
- Timeout counter (16 bits):
  - Clears on grant.
  - Increments each busy cycle without `c_ready`; saturates.
  - When count reaches TIMEOUT-1 while still busy, `err_timeout` sets and stays set until reset.
  - The FSM is not affected.
- A dropped store is still performed downstream. This is acceptable, because the pipeline only flushes a memory-stage store on exception, and that flush comes after memory issue.

## Timing
- Reset (asynchronous assert, synchronous release): state IDLE; `c_valid`, `c_write`, `err_timeout`, `i_ready`, `d_ready` = 0; `c_addr`, `c_size`, `c_strobe`, `c_wdata` = 0; counter 0.
- Reset asserted mid-transaction: `c_valid` drops immediately (asynchronously). The in-flight response is lost.
- Request latency:
  - Request seen high in IDLE at edge N.
  - `c_valid`=1 from cycle N+1.
- Completion latency:
  - `c_ready` at cycle M → requester ready in cycle M.
  - State IDLE at M+1; `c_valid`=0 in M+1.
  - Next grant evaluated in M+1; next `c_valid` at M+2. Minimum one idle bubble between transactions.
- `c_ready` arriving while IDLE is ignored.
- Request changes during busy do not alter `c_*`. They only affect the match check at completion.

## Test plan
- Fetch only:
  - Stimulus: `i_valid`=1, `i_addr`=0x8000_0000; `c_ready` 3 cycles after `c_valid` with `c_rdata`=0x13.
  - Required: `c_size`=3'b010; `i_ready`=1 for exactly that cycle; `i_rdata`=0x13; `c_valid`=0 the next cycle.
- Simultaneous requests:
  - Stimulus: `i_valid` and `d_valid` (load at 0x8000_1000) rise together.
  - Required: the data access is issued first, and `d_ready` pulses on its completion. The fetch is then issued at `c_valid` two cycles after that completion.
- Flush mid-fetch:
  - Stimulus: while BUSY_I on 0x8000_0000, `i_addr` changes to 0x8000_0100 before `c_ready`.
  - Required: no `i_ready` on that completion; the next transaction has `c_addr`=0x8000_0100.
- Store pass-through:
  - Stimulus: `d_write`=1, `d_strobe`=0x0F, `d_wdata`=0xDEAD_BEEF, `d_size`=3'b010.
  - Required: the `c_*` fields match the request and are stable until `c_ready`; then `d_ready` pulses once.
- Reset mid-transaction:
  - Stimulus: `reset`=0 while `c_valid`=1.
  - Required: `c_valid`=0 without waiting for a clock edge; after release, state IDLE and `err_timeout`=0.
- Timeout:
  - Stimulus: TIMEOUT=8; issue a request and never assert `c_ready`.
  - Required: `err_timeout` rises 8 cycles after `c_valid` rises and remains 1; `c_valid` stays 1.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between the fetch and memory stages.
// The granted request is latched into the c_* registers and held until the
// memory completes. The response goes back only to a requester that still
// presents the same request; flushed requests are retired silently.
module mem_arbiter #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_valid,
    input  logic [63:0] i_addr,
    output logic        i_ready,
    output logic [63:0] i_rdata,
    input  logic        d_valid,
    input  logic [63:0] d_addr,
    input  logic        d_write,
    input  logic [2:0]  d_size,
    input  logic [7:0]  d_strobe,
    input  logic [63:0] d_wdata,
    output logic        d_ready,
    output logic [63:0] d_rdata,
    output logic        c_valid,
    output logic [63:0] c_addr,
    output logic        c_write,
    output logic [2:0]  c_size,
    output logic [7:0]  c_strobe,
    output logic [63:0] c_wdata,
    input  logic        c_ready,
    input  logic [63:0] c_rdata,
    output logic        err_timeout
);

    typedef enum logic [1:0] {
        StIdle,
        StBusyI,
        StBusyD
    } state_e;

    // Count value at which an outstanding transaction is declared stuck.
    localparam logic [15:0] TimeoutLast = 16'(TIMEOUT - 1);

    state_e      state_q;
    logic [15:0] cnt_q;

    // Arbitration FSM with registered downstream request and timeout tracking.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            c_valid     <= 1'b0;
            c_addr      <= '0;
            c_write     <= 1'b0;
            c_size      <= '0;
            c_strobe    <= '0;
            c_wdata     <= '0;
            err_timeout <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    // Data has priority: a stalled memory stage blocks the whole pipe.
                    if (d_valid) begin
                        state_q  <= StBusyD;
                        cnt_q    <= '0;
                        c_valid  <= 1'b1;
                        c_addr   <= d_addr;
                        c_write  <= d_write;
                        c_size   <= d_size;
                        c_strobe <= d_strobe;
                        c_wdata  <= d_wdata;
                    end else if (i_valid) begin
                        state_q  <= StBusyI;
                        cnt_q    <= '0;
                        c_valid  <= 1'b1;
                        c_addr   <= i_addr;
                        c_write  <= 1'b0;
                        c_size   <= 3'b010;
                        c_strobe <= '0;
                        c_wdata  <= '0;
                    end
                end
                StBusyI, StBusyD: begin
                    if (c_ready) begin
                        state_q <= StIdle;
                        c_valid <= 1'b0;
                    end else begin
                        if (cnt_q != 16'hFFFF) begin
                            cnt_q <= cnt_q + 16'd1;
                        end
                        // Sticky flag only; the transaction keeps waiting.
                        if (cnt_q >= TimeoutLast) begin
                            err_timeout <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                    c_valid <= 1'b0;
                end
            endcase
        end
    end

    // Response routing: deliver only if the requester still asks for the same address.
    always_comb begin
        i_rdata = c_rdata;
        d_rdata = c_rdata;
        i_ready = c_ready && (state_q == StBusyI) && i_valid && (i_addr == c_addr);
        d_ready = c_ready && (state_q == StBusyD) && d_valid && (d_addr == c_addr);
    end

endmodule
